// File: rtl/run_length_detector.sv
// run_length_detector: flags runs of N equal qualified bits on a serial stream, with saturating run and hit counters
module run_length_detector #(
  parameter int CNT_W = 5,
  parameter int HIT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             w,
  input  logic [CNT_W-1:0] run_len,
  input  logic [1:0]       mode,
  input  logic             clr_hits,
  output logic             z,
  output logic             z0,
  output logic             z1,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] run_cnt,
  output logic [HIT_W-1:0] hit_cnt
);
  typedef enum logic [2:0] {S_INIT = 3'b001, S_ZERO = 3'b010, S_ONE = 3'b100} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [HIT_W-1:0] HIT_MAX = '1;
  state_t state_q, state_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d, thr, run_inc;
  logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic legal, hit;
  assign thr     = (run_len == '0) ? CNT_W'(1) : run_len;
  assign run_inc = (run_cnt_q == CNT_MAX) ? CNT_MAX : run_cnt_q + CNT_W'(1);
  assign legal   = state_q inside {S_INIT, S_ZERO, S_ONE};
  // Next state and run length; a run restarts at 1 whenever the polarity changes
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    if (!legal) begin
      state_d   = S_INIT;
      run_cnt_d = '0;
    end else if (en) begin
      state_d   = w ? S_ONE : S_ZERO;
      run_cnt_d = (state_d == state_q) ? run_inc : CNT_W'(1);
    end
  end
  // Count a run once, on the update where its length first equals the threshold
  always_comb begin
    hit = legal & en & (run_cnt_d == thr)
        & ((state_d != state_q) | (run_cnt_d != run_cnt_q))
        & ((state_d == S_ZERO) ? mode[0] : mode[1]);
    hit_cnt_d = clr_hits ? '0 : (hit && hit_cnt_q != HIT_MAX) ? hit_cnt_q + HIT_W'(1) : hit_cnt_q;
  end
  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_INIT;
      run_cnt_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end
  assign z0      = state_q[1] & (run_cnt_q >= thr) & mode[0];
  assign z1      = state_q[2] & (run_cnt_q >= thr) & mode[1];
  assign z       = z0 | z1;
  assign state   = state_q;
  assign run_cnt = run_cnt_q;
  assign hit_cnt = hit_cnt_q;
endmodule

// File: tb/tb_run_length_detector.sv
// tb_run_length_detector: directed vectors with hand-computed expectations
module tb_run_length_detector;
  logic clk = 0, reset = 1, en = 0, w = 0, clr_hits = 0;
  logic [4:0] run_len = 5'd4;
  logic [1:0] mode = 2'b11;
  logic z, z0, z1, zb, z0b, z1b;
  logic [2:0] state, state_b, run_cnt_b;
  logic [4:0] run_cnt;
  logic [7:0] hit_cnt, hit_cnt_b;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  run_length_detector #(.CNT_W(5), .HIT_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .w(w), .run_len(run_len), .mode(mode),
    .clr_hits(clr_hits), .z(z), .z0(z0), .z1(z1), .state(state),
    .run_cnt(run_cnt), .hit_cnt(hit_cnt)
  );
  run_length_detector #(.CNT_W(3), .HIT_W(8)) dut_b (
    .clk(clk), .reset(reset), .en(en), .w(w), .run_len(run_len[2:0]), .mode(mode),
    .clr_hits(clr_hits), .z(zb), .z0(z0b), .z1(z1b), .state(state_b),
    .run_cnt(run_cnt_b), .hit_cnt(hit_cnt_b)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask
  initial begin
    tick();
    reset = 0;
    chk("rst_state", state, 3'b001);
    chk("rst_run", run_cnt, 0);
    chk("rst_hit", hit_cnt, 0);
    chk("rst_z", z, 0);
    // four zeros in a row
    en = 1;
    w = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t1_z_low", z, 0);
      chk("t1_run", run_cnt, i);
    end
    tick();
    chk("t1_z", z, 1);
    chk("t1_z0", z0, 1);
    chk("t1_run4", run_cnt, 4);
    chk("t1_hit", hit_cnt, 1);
    w = 1;
    tick();
    chk("t1_z_fall", z, 0);
    chk("t1_state", state, 3'b100);
    chk("t1_run1", run_cnt, 1);
    // mode masking
    do_reset();
    mode = 2'b01;
    run_len = 3;
    w = 1;
    repeat (5) begin
      tick();
      chk("t2_z1_masked", z1, 0);
    end
    chk("t2_run", run_cnt, 5);
    chk("t2_hit", hit_cnt, 0);
    mode = 2'b11;
    #1;
    chk("t2_z1_now", z1, 1);
    en = 0;
    tick();
    chk("t2_hold_run", run_cnt, 5);
    chk("t2_hold_hit", hit_cnt, 0);
    // en gaps
    do_reset();
    en = 1; w = 1; tick();
    en = 0; w = 0; tick(); tick();
    chk("t3_hold_state", state, 3'b100);
    chk("t3_hold_run", run_cnt, 1);
    en = 1; w = 1; tick();
    chk("t3_run2", run_cnt, 2);
    chk("t3_z1_low", z1, 0);
    tick();
    chk("t3_run3", run_cnt, 3);
    chk("t3_z1", z1, 1);
    chk("t3_hit", hit_cnt, 1);
    // saturation on the 3-bit instance
    do_reset();
    run_len = 7;
    w = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("t4_z0b", z0b, (i >= 7) ? 1 : 0);
      chk("t4_runb", run_cnt_b, (i >= 7) ? 7 : i);
    end
    chk("t4_hitb", hit_cnt_b, 1);
    chk("t4_run_wide", run_cnt, 12);
    chk("t4_hit_wide", hit_cnt, 1);
    // run_len=0 acts as 1, then clear
    do_reset();
    run_len = 0;
    for (int i = 1; i <= 4; i++) begin
      w = ~i[0];
      tick();
      chk("t5_z", z, 1);
      chk("t5_hit", hit_cnt, i);
    end
    clr_hits = 1;
    w = 0;
    tick();
    clr_hits = 0;
    chk("t5_clr_hit", hit_cnt, 0);
    chk("t5_clr_state", state, 3'b010);
    chk("t5_clr_z", z, 1);
    // reset in the middle of a detected run
    do_reset();
    run_len = 2;
    w = 1;
    repeat (3) tick();
    chk("t6_z_pre", z, 1);
    chk("t6_hit_pre", hit_cnt, 1);
    reset = 1;
    #1;
    chk("t6_state_before_edge", state, 3'b100);
    chk("t6_z_before_edge", z, 1);
    tick();
    reset = 0;
    chk("t6_state", state, 3'b001);
    chk("t6_run", run_cnt, 0);
    chk("t6_hit", hit_cnt, 0);
    chk("t6_z", z, 0);
    w = 0;
    tick();
    chk("t6_new_run", run_cnt, 1);
    chk("t6_new_state", state, 3'b010);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
